// File: rtl/posit_batch_sequencer.sv
// rtl/posit_batch_sequencer.sv - batch sequencer feeding memory operand pairs through a posit unit
// One element per pass: read both memories, hand operands to the unit, write the result back over A.
module posit_batch_sequencer #(
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W:0]       count,
    input  logic [1:0]            op,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_W:0]       processed,
    output logic [ADDR_W-1:0]     m0_address,
    output logic                  m0_chipselect,
    output logic                  m0_clken,
    output logic                  m0_write,
    output logic [DATA_W-1:0]     m0_writedata,
    output logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic [DATA_W-1:0]     m0_readdata,
    output logic [ADDR_W-1:0]     m1_address,
    output logic                  m1_chipselect,
    output logic                  m1_clken,
    output logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_readdata,
    output logic                  pu_in_valid,
    input  logic                  pu_in_ready,
    output logic [DATA_W-1:0]     pu_num1,
    output logic [DATA_W-1:0]     pu_num2,
    output logic [1:0]            pu_op,
    input  logic                  pu_out_valid,
    input  logic [DATA_W-1:0]     pu_result
);
    localparam int TCW = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_CAPTURE, S_ISSUE, S_WAIT, S_WRITE, S_DONE, S_ERROR
    } state_t;

    state_t state, state_next;

    logic                start_q;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W:0]     count_q;
    logic [1:0]          op_q;
    logic [ADDR_W:0]     idx;
    logic [DATA_W-1:0]   a_q, b_q, res_q;
    logic [TCW-1:0]      tcnt;

    logic                start_edge, can_start, timed_out;
    logic [ADDR_W-1:0]   elem_addr;

    assign start_edge = start & ~start_q;
    assign can_start  = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
    assign timed_out  = (tcnt == TCW'(TIMEOUT - 1));
    // Address arithmetic is deliberately modulo the memory size so batches may wrap.
    assign elem_addr  = base_q + idx[ADDR_W-1:0];
    assign pu_op      = op_q;
    assign m1_write   = 1'b0;

    always_comb begin
        state_next    = state;
        m0_address    = '0;
        m0_chipselect = 1'b0;
        m0_clken      = 1'b0;
        m0_write      = 1'b0;
        m0_writedata  = '0;
        m0_byteenable = '0;
        m1_address    = '0;
        m1_chipselect = 1'b0;
        m1_clken      = 1'b0;
        pu_in_valid   = 1'b0;
        pu_num1       = '0;
        pu_num2       = '0;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_edge) state_next = (count == '0) ? S_DONE : S_READ;
            end
            S_READ: begin
                m0_address    = elem_addr;
                m0_chipselect = 1'b1;
                m0_clken      = 1'b1;
                m1_address    = elem_addr;
                m1_chipselect = 1'b1;
                m1_clken      = 1'b1;
                state_next    = S_CAPTURE;
            end
            S_CAPTURE: state_next = S_ISSUE;
            S_ISSUE: begin
                pu_in_valid = 1'b1;
                pu_num1     = a_q;
                pu_num2     = b_q;
                if (pu_in_ready)    state_next = S_WAIT;
                else if (timed_out) state_next = S_ERROR;
            end
            S_WAIT: begin
                if (pu_out_valid)   state_next = S_WRITE;
                else if (timed_out) state_next = S_ERROR;
            end
            S_WRITE: begin
                m0_address    = elem_addr;
                m0_chipselect = 1'b1;
                m0_clken      = 1'b1;
                m0_write      = 1'b1;
                m0_writedata  = res_q;
                m0_byteenable = '1;
                state_next    = ((idx + IDX_ONE) == count_q) ? S_DONE : S_READ;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            start_q   <= 1'b1;
            base_q    <= '0;
            count_q   <= '0;
            op_q      <= '0;
            idx       <= '0;
            processed <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            tcnt      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state   <= state_next;
            start_q <= start;
            if (can_start && start_edge) begin
                base_q    <= base_addr;
                count_q   <= count;
                op_q      <= op;
                idx       <= '0;
                processed <= '0;
                done      <= 1'b0;
                error     <= 1'b0;
                busy      <= 1'b1;
            end else begin
                case (state)
                    S_CAPTURE: begin
                        a_q  <= m0_readdata;
                        b_q  <= m1_readdata;
                        tcnt <= '0;
                    end
                    S_ISSUE: tcnt <= tcnt + TCW'(1);
                    S_WAIT: begin
                        tcnt <= tcnt + TCW'(1);
                        if (pu_out_valid) res_q <= pu_result;
                    end
                    S_WRITE: begin
                        idx       <= idx + IDX_ONE;
                        processed <= processed + IDX_ONE;
                    end
                    S_DONE: begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                    S_ERROR: begin
                        busy  <= 1'b0;
                        error <= 1'b1;
                        done  <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_posit_batch_sequencer.sv
// tb/tb_posit_batch_sequencer.sv - self-checking bench for posit_batch_sequencer
module tb_posit_batch_sequencer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b1;
    logic [10:0] base_addr = '0;
    logic [11:0] count = '0;
    logic [1:0]  op = '0;
    logic        busy, done, error;
    logic [11:0] processed;
    logic [10:0] m0_address, m1_address;
    logic        m0_chipselect, m0_clken, m0_write, m1_chipselect, m1_clken, m1_write;
    logic [15:0] m0_writedata, pu_num1, pu_num2;
    logic [1:0]  m0_byteenable, pu_op;
    logic [15:0] m0_rd = '0, m1_rd = '0;
    logic        pu_in_valid;
    logic        u_ready = 1'b0, u_ovalid = 1'b0;
    logic [15:0] u_res = '0;

    posit_batch_sequencer #(.ADDR_W(11), .DATA_W(16), .TIMEOUT(16)) dut (
        .clock(clock), .reset(reset), .start(start), .base_addr(base_addr), .count(count), .op(op),
        .busy(busy), .done(done), .error(error), .processed(processed),
        .m0_address(m0_address), .m0_chipselect(m0_chipselect), .m0_clken(m0_clken),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_readdata(m0_rd), .m1_address(m1_address), .m1_chipselect(m1_chipselect),
        .m1_clken(m1_clken), .m1_write(m1_write), .m1_readdata(m1_rd),
        .pu_in_valid(pu_in_valid), .pu_in_ready(u_ready), .pu_num1(pu_num1), .pu_num2(pu_num2),
        .pu_op(pu_op), .pu_out_valid(u_ovalid), .pu_result(u_res));

    always #5 clock = ~clock;

    int tests = 0, fails = 0;

    // Stand-in arithmetic unit: a few exact posit16 (es=1) sums, otherwise an arbitrary mix.
    function automatic logic [15:0] unit_fn(input logic [15:0] a, input logic [15:0] b, input logic [1:0] o);
        if (o == 2'd0 && a == 16'h4000 && b == 16'h4000) return 16'h5000;
        if (o == 2'd0 && a == 16'h4000 && b == 16'h5000) return 16'h5800;
        if (o == 2'd0 && a == 16'h3000 && b == 16'h3000) return 16'h4000;
        return (a ^ {b[7:0], b[15:8]}) + {14'd0, o} + 16'h0101;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Memory models (1-cycle read latency) plus a backdoor loader and an access log.
    logic [15:0] mem0 [2048];
    logic [15:0] mem1 [2048];
    logic [15:0] ref_mem0 [2048];
    logic [15:0] ref_mem1 [2048];
    logic        bd_we = 1'b0;
    logic [10:0] bd_addr = '0;
    logic [15:0] bd_d0 = '0, bd_d1 = '0;
    int          wr_cnt = 0, rd_n = 0, mon_err = 0;
    logic [10:0] rd_log [256];

    always @(posedge clock) begin
        if (bd_we) begin
            mem0[bd_addr] <= bd_d0;
            mem1[bd_addr] <= bd_d1;
        end
        if (m0_chipselect && m0_clken) begin
            if (m0_write) begin
                mem0[m0_address] <= m0_writedata;
                wr_cnt <= wr_cnt + 1;
                if (m0_byteenable != 2'b11) mon_err <= mon_err + 1;
            end else begin
                m0_rd <= mem0[m0_address];
                rd_log[rd_n % 256] <= m0_address;
                rd_n <= rd_n + 1;
                if (!(m1_chipselect && m1_clken) || m1_address != m0_address) mon_err <= mon_err + 1;
            end
        end
        if (m1_chipselect && m1_clken) m1_rd <= mem1[m1_address];
        if (m1_write) mon_err <= mon_err + 1;
    end

    // Posit-unit model: ready after u_dly ISSUE cycles, result u_lat cycles after acceptance.
    int          u_dly = 0, u_lat = 1, u_mute = -1, batch_id = 0;
    logic [15:0] exp_a [64];
    logic [15:0] exp_b [64];
    logic [10:0] exp_addr [64];
    logic [1:0]  exp_op = '0;
    int          opnd_err = 0;
    int          u_seen = 0, acc_n = 0, iss_n = 0, cnt_l = 0;
    bit          pend = 0, last_v = 0;
    logic [15:0] last_a = '0, last_b = '0;
    logic [1:0]  last_op = '0;

    always @(negedge clock) begin
        if (batch_id != u_seen) begin
            u_seen = batch_id; pend = 0; acc_n = 0; iss_n = 0; last_v = 0; u_ready = 1'b0;
        end
        u_ovalid = 1'b0;
        if (pend) begin
            cnt_l--;
            if (cnt_l == 0) begin u_ovalid = 1'b1; pend = 0; end
        end
        if (last_v && u_ready) begin
            if (acc_n >= 64 || last_a != exp_a[acc_n] || last_b != exp_b[acc_n] || last_op != exp_op)
                opnd_err++;
            u_res = unit_fn(last_a, last_b, last_op);
            if (acc_n != u_mute) begin
                if (u_lat <= 1) u_ovalid = 1'b1;
                else begin pend = 1; cnt_l = u_lat - 1; end
            end
            acc_n++;
            iss_n = 0;
        end else if (last_v && pu_in_valid && (pu_num1 != last_a || pu_num2 != last_b)) begin
            opnd_err++;
        end
        u_ready = 1'b0;
        if (pu_in_valid) begin
            u_ready = (iss_n >= u_dly);
            iss_n++;
        end
        last_v = pu_in_valid; last_a = pu_num1; last_b = pu_num2; last_op = pu_op;
    end

    task automatic bd_write(input logic [10:0] a, input logic [15:0] d0, input logic [15:0] d1);
        @(negedge clock);
        bd_addr = a; bd_d0 = d0; bd_d1 = d1; bd_we = 1'b1;
        ref_mem0[a] = d0; ref_mem1[a] = d1;
        @(posedge clock);
        #1 bd_we = 1'b0;
    endtask

    task automatic preload_rand(input logic [10:0] base, input int cnt);
        for (int i = 0; i < cnt; i++)
            bd_write(11'((int'(base) + i) % 2048), 16'($urandom), 16'($urandom));
    endtask

    // Runs one batch; returns edges from the start edge to done/error and busy-high samples.
    task automatic run_batch(input logic [10:0] base, input int cnt, input logic [1:0] opc,
                             input int dly, input int lat, input bit abuse, input int mute,
                             input int exp_proc, output int j, output int busy_cnt);
        int wr0, rd0, n_rd, bad;
        u_dly = dly; u_lat = lat; u_mute = mute; exp_op = opc;
        for (int i = 0; i < cnt; i++) begin
            exp_addr[i] = 11'((int'(base) + i) % 2048);
            exp_a[i] = ref_mem0[exp_addr[i]];
            exp_b[i] = ref_mem1[exp_addr[i]];
        end
        @(negedge clock);
        batch_id++;
        wr0 = wr_cnt; rd0 = rd_n;
        base_addr = base; count = 12'(cnt); op = opc; start = 1'b1;
        @(posedge clock);
        j = 0; busy_cnt = 0;
        while (j < 400) begin
            @(negedge clock);
            start = abuse && (j < 33) && j[0];
            if (done || error) break;
            busy_cnt += int'(busy);
            @(posedge clock);
            j++;
        end
        start = 1'b0;
        for (int i = 0; i < exp_proc; i++)
            ref_mem0[exp_addr[i]] = unit_fn(exp_a[i], exp_b[i], opc);
        check("processed", processed, exp_proc);
        check("write_count", wr_cnt - wr0, exp_proc);
        n_rd = rd_n - rd0;
        check("read_count", n_rd, (mute >= 0) ? exp_proc + 1 : cnt);
        bad = 0;
        for (int k = 0; k < n_rd && k < 64; k++)
            if (rd_log[(rd0 + k) % 256] != exp_addr[k]) bad++;
        check("read_order", bad, 0);
        bad = 0;
        for (int i = 0; i < cnt; i++)
            if (mem0[exp_addr[i]] != ref_mem0[exp_addr[i]]) bad++;
        check("mem_data", bad, 0);
        check("operands", opnd_err, 0);
        check("bus_protocol", mon_err, 0);
    endtask

    typedef struct {
        logic [10:0] base;
        int          cnt;
        logic [1:0]  opc;
        int          dly;
        int          lat;
        bit          abuse;
        int          exp_cycles;
        int          exp_proc;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[5];
        int   j, bc, wr0;
        vecs[0] = '{11'h000, 3, 2'd0, 0, 1, 1'b0, 16, 3};
        vecs[1] = '{11'h7FE, 4, 2'd1, 0, 1, 1'b0, 21, 4};
        vecs[2] = '{11'h010, 0, 2'd2, 0, 1, 1'b0,  1, 0};
        vecs[3] = '{11'h100, 2, 2'd2, 4, 7, 1'b0, 31, 2};
        vecs[4] = '{11'h3F0, 5, 2'd3, 1, 2, 1'b1, 36, 5};

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_outputs", |{busy, done, error, processed, m0_address, m0_chipselect, m0_clken,
              m0_write, m0_writedata, m0_byteenable, m1_address, m1_chipselect, m1_clken, m1_write,
              pu_in_valid, pu_num1, pu_num2, pu_op}, 0);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("start_held_through_reset", busy, 0);
        start = 1'b0;

        bd_write(11'h000, 16'h4000, 16'h4000);
        bd_write(11'h001, 16'h4000, 16'h5000);
        bd_write(11'h002, 16'h3000, 16'h3000);
        for (int v = 0; v < 5; v++) begin
            if (v > 0) preload_rand(vecs[v].base, vecs[v].cnt);
            run_batch(vecs[v].base, vecs[v].cnt, vecs[v].opc, vecs[v].dly, vecs[v].lat,
                      vecs[v].abuse, -1, vecs[v].exp_proc, j, bc);
            check("done_latency", j, vecs[v].exp_cycles);
            check("busy_cycles", bc, vecs[v].exp_cycles);
            check("done_flag", {done, error}, 2);
            if (v == 0)
                check("add_results", {mem0[0], mem0[1], mem0[2]}, {16'h5000, 16'h5800, 16'h4000});
        end

        // Timeout on the second of four elements, then a fresh start reruns the batch.
        preload_rand(11'h050, 4);
        run_batch(11'h050, 4, 2'd1, 0, 1, 1'b0, 1, 1, j, bc);
        check("timeout_flags", {error, busy, done}, 3'b100);
        run_batch(11'h050, 4, 2'd1, 0, 1, 1'b0, -1, 4, j, bc);
        check("rerun_latency", j, 21);
        check("rerun_flags", {done, error}, 2);

        // Reset while waiting for a result: outputs clear, the late result is never written.
        preload_rand(11'h200, 3);
        u_dly = 0; u_lat = 12; u_mute = -1; exp_op = 2'd2;
        for (int i = 0; i < 3; i++) begin
            exp_addr[i] = 11'h200 + 11'(i);
            exp_a[i] = ref_mem0[exp_addr[i]];
            exp_b[i] = ref_mem1[exp_addr[i]];
        end
        @(negedge clock);
        batch_id++;
        base_addr = 11'h200; count = 12'd3; op = 2'd2; start = 1'b1;
        @(posedge clock);
        repeat (5) begin
            @(negedge clock);
            start = 1'b0;
        end
        check("in_wait_before_reset", {busy, pu_in_valid}, 2'b10);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("reset_mid_wait_outputs", |{busy, done, error, processed, m0_chipselect, m0_clken,
              m0_write, m0_address, m0_writedata, m1_chipselect, pu_in_valid, pu_num1, pu_num2, pu_op}, 0);
        wr0 = wr_cnt;
        reset = 1'b0;
        repeat (20) @(negedge clock);
        check("no_write_after_reset", wr_cnt - wr0, 0);
        check("mem_after_reset", mem0[11'h200], ref_mem0[11'h200]);

        // Randomised batches against the reference model.
        for (int r = 0; r < 6; r++) begin
            logic [10:0] b;
            int c, d, l;
            logic [1:0] o;
            b = 11'($urandom_range(0, 2047));
            c = int'($urandom_range(1, 6));
            d = int'($urandom_range(0, 3));
            l = int'($urandom_range(1, 5));
            o = 2'($urandom);
            preload_rand(b, c);
            run_batch(b, c, o, d, l, 1'b0, -1, c, j, bc);
            check("rand_latency", j, 1 + c * (4 + d + l));
            check("rand_busy", bc, 1 + c * (4 + d + l));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
